// File: rtl/lstm_bp_pkg.sv
// Shared definitions for the LSTM backward-pass address generators.
// Contents: FSM state encoding, gate word offsets within an activation
// group (a,i,f,o), and the number of gates per cell.
package lstm_bp_pkg;

  // Gates stored per (t,n) activation group.
  localparam int unsigned GATES      = 4;
  localparam int unsigned GATE_SHIFT = $clog2(GATES);

  // Word offset of each gate inside its activation group.
  typedef enum logic [1:0] {
    G_A = 2'd0,
    G_I = 2'd1,
    G_F = 2'd2,
    G_O = 2'd3
  } gate_e;

  // Sweep controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } bp_state_e;

endpackage

// File: rtl/addr_gen_bwd_aifo_if.sv
// Handshake/address bundle between the backward-pass address generator and
// the dgate/dstate datapath control.
//  start, en            : control towards the generator
//  o_valid              : addresses valid this cycle
//  o_addr_act/ch/cprev  : activation base, c/h word, c_(t-1) word
//  o_first_ts/last_cell : position flags for the current beat
//  o_done               : sweep-complete pulse
interface addr_gen_bwd_aifo_if #(
  parameter int unsigned ADDR_WIDTH = 12
);

  logic                  start;
  logic                  en;
  logic                  o_valid;
  logic [ADDR_WIDTH-1:0] o_addr_act;
  logic [ADDR_WIDTH-1:0] o_addr_ch;
  logic [ADDR_WIDTH-1:0] o_addr_cprev;
  logic                  o_first_ts;
  logic                  o_last_cell;
  logic                  o_done;

  // Controller side: drives start/en, consumes addresses.
  modport master (
    output start, en,
    input  o_valid, o_addr_act, o_addr_ch, o_addr_cprev,
    input  o_first_ts, o_last_cell, o_done
  );

  // Generator side.
  modport slave (
    input  start, en,
    output o_valid, o_addr_act, o_addr_ch, o_addr_cprev,
    output o_first_ts, o_last_cell, o_done
  );

endinterface

// File: rtl/bp_pause_cnt.sv
// Loadable down counter used to time the idle gap between timesteps.
//  clk, rst  : clock, synchronous active-high reset
//  load      : load load_val (has priority over en)
//  load_val  : value to load
//  en        : decrement enable; the counter saturates at zero
//  zero      : counter currently reads zero
module bp_pause_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/addr_gen_bwd_aifo.sv
// Backward-pass (BPTT) read address generator for LSTM layer memories.
// Walks timesteps t = TIMESTEP-1 .. 0 and cells n = 0 .. NUM_CELL-1, producing
// the activation group base, the c/h word and the c_(t-1) word for each beat.
// Layout: act word = (t*NUM_CELL+n)*GATES + g, c/h word = t*NUM_CELL + n.
// A single running index base_c = t*NUM_CELL+n replaces all multiplies.
//  clk, rst : clock, synchronous active-high reset
//  bus      : addr_gen_bwd_aifo_if slave (start/en in, addresses/flags out)
module addr_gen_bwd_aifo
  import lstm_bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_CELL   = 53,
  parameter int unsigned TIMESTEP   = 7,
  parameter int unsigned DELAY      = 4
) (
  input  logic                clk,
  input  logic                rst,
  addr_gen_bwd_aifo_if.slave  bus
);

  localparam int unsigned T_W = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam int unsigned N_W = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
  localparam int unsigned C_W = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [T_W-1:0]        T_FIRST    = T_W'(TIMESTEP - 1);
  localparam logic [N_W-1:0]        N_LAST     = N_W'(NUM_CELL - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_START = ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELL);
  // From (t, NUM_CELL-1) back to (t-1, 0).
  localparam logic [ADDR_WIDTH-1:0] STEP_BACK  = ADDR_WIDTH'(2 * NUM_CELL - 1);
  localparam logic [ADDR_WIDTH-1:0] CELL_STEP  = ADDR_WIDTH'(NUM_CELL);
  localparam logic [C_W-1:0]        PAUSE_LOAD = C_W'((DELAY > 0) ? DELAY - 1 : 0);
  localparam bit                    HAS_PAUSE  = (DELAY > 0);

  // Address space must hold every activation word.
  if (64'(TIMESTEP) * 64'(NUM_CELL) * 64'(GATES) > (64'(1) << ADDR_WIDTH)) begin : g_cfg_err
    $error("addr_gen_bwd_aifo: ADDR_WIDTH too small for TIMESTEP*NUM_CELL*GATES");
  end

  bp_state_e             state, state_d;
  logic [T_W-1:0]        t, t_d;
  logic [N_W-1:0]        n, n_d;
  logic [ADDR_WIDTH-1:0] base_c, base_d;
  logic                  cnt_load, cnt_en, cnt_zero;
  logic                  valid_c;

  // State and position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      t      <= '0;
      n      <= '0;
      base_c <= '0;
    end else begin
      state  <= state_d;
      t      <= t_d;
      n      <= n_d;
      base_c <= base_d;
    end
  end

  // Next-state, position update and counter control.
  always_comb begin
    state_d  = state;
    t_d      = t;
    n_d      = n;
    base_d   = base_c;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    valid_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          t_d     = T_FIRST;
          n_d     = '0;
          base_d  = BASE_START;
        end
      end
      S_RUN: begin
        valid_c = bus.en;
        if (bus.en) begin
          if (n == N_LAST) begin
            // base_c is left on the last beat so addresses hold through the gap.
            if (t == '0) begin
              state_d = S_DONE;
            end else if (HAS_PAUSE) begin
              state_d  = S_PAUSE;
              cnt_load = 1'b1;
            end else begin
              t_d    = t - T_W'(1);
              n_d    = '0;
              base_d = base_c - STEP_BACK;
            end
          end else begin
            n_d    = n + N_W'(1);
            base_d = base_c + ADDR_WIDTH'(1);
          end
        end
      end
      S_PAUSE: begin
        if (bus.en) begin
          if (cnt_zero) begin
            state_d = S_RUN;
            t_d     = t - T_W'(1);
            n_d     = '0;
            base_d  = base_c - STEP_BACK;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Inter-timestep gap timer.
  bp_pause_cnt #(
    .WIDTH (C_W)
  ) u_pause_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (PAUSE_LOAD),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Outputs derive from registered state; o_valid follows en with zero latency.
  assign bus.o_valid      = valid_c;
  assign bus.o_addr_act   = (base_c << GATE_SHIFT) + ADDR_WIDTH'(G_A);
  assign bus.o_addr_ch    = base_c;
  assign bus.o_addr_cprev = (t == '0) ? '0 : (base_c - CELL_STEP);
  assign bus.o_first_ts   = (state == S_RUN) && (t == '0);
  assign bus.o_last_cell  = (state == S_RUN) && (n == N_LAST);
  assign bus.o_done       = (state == S_DONE);

endmodule

// File: tb/tb_addr_gen_bwd_aifo.sv
// Directed bench for addr_gen_bwd_aifo.
// dut_a: NUM_CELL=3, TIMESTEP=2, DELAY=2 (table-driven sweep, stall, reset)
// dut_b: NUM_CELL=3, TIMESTEP=2, DELAY=0 (back-to-back timesteps)
// dut_c: default parameters (beat/pause totals)
module tb_addr_gen_bwd_aifo;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  addr_gen_bwd_aifo_if #(.ADDR_WIDTH(12)) ifa ();
  addr_gen_bwd_aifo_if #(.ADDR_WIDTH(12)) ifb ();
  addr_gen_bwd_aifo_if #(.ADDR_WIDTH(12)) ifc ();

  addr_gen_bwd_aifo #(.ADDR_WIDTH(12), .NUM_CELL(3), .TIMESTEP(2), .DELAY(2))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  addr_gen_bwd_aifo #(.ADDR_WIDTH(12), .NUM_CELL(3), .TIMESTEP(2), .DELAY(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  addr_gen_bwd_aifo #(.ADDR_WIDTH(12), .NUM_CELL(53), .TIMESTEP(7), .DELAY(4))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        en;
    logic        valid;
    logic [11:0] ch;
    logic [11:0] act;
    logic [11:0] cprev;
    logic        first;
    logic        last;
    logic        done;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifa.start = 1'b0; ifa.en = 1'b1;
    ifb.start = 1'b0; ifb.en = 1'b1;
    ifc.start = 1'b0; ifc.en = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, input logic e, input logic v, input int ch,
                              input int act, input int cp, input logic f, input logic l,
                              input logic d);
    vec_t r;
    r.start = s; r.en = e; r.valid = v;
    r.ch = 12'(ch); r.act = 12'(act); r.cprev = 12'(cp);
    r.first = f; r.last = l; r.done = d;
    return r;
  endfunction

  // Apply the sweep table to dut_a; optionally pulse start during RUN and PAUSE.
  task automatic run_table(input string tag, input bit inject);
    for (int i = 0; i < 11; i++) begin
      ifa.start = vecs[i].start | (inject && (i == 2 || i == 4));
      ifa.en    = vecs[i].en;
      @(negedge clk);
      chk($sformatf("%s[%0d].valid", tag, i), 32'(ifa.o_valid),      32'(vecs[i].valid));
      chk($sformatf("%s[%0d].ch", tag, i),    32'(ifa.o_addr_ch),    32'(vecs[i].ch));
      chk($sformatf("%s[%0d].act", tag, i),   32'(ifa.o_addr_act),   32'(vecs[i].act));
      chk($sformatf("%s[%0d].cprev", tag, i), 32'(ifa.o_addr_cprev), 32'(vecs[i].cprev));
      chk($sformatf("%s[%0d].first", tag, i), 32'(ifa.o_first_ts),   32'(vecs[i].first));
      chk($sformatf("%s[%0d].last", tag, i),  32'(ifa.o_last_cell),  32'(vecs[i].last));
      chk($sformatf("%s[%0d].done", tag, i),  32'(ifa.o_done),       32'(vecs[i].done));
      step();
    end
    ifa.start = 1'b0;
  endtask

  // Let dut_a run to its done pulse within a cycle budget.
  task automatic drain_a(input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (ifa.o_done) seen = 1;
      step();
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int beats, pauses, dones, first_ch, first_act, last_ch, last_act, cyc;
    int exp_ch[6];
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;

    //              st en v  ch act cp f  l  d
    vecs[0]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 3, 12, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 4, 16, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 5, 20, 2, 0, 1, 0);
    vecs[4]  = mk(0, 1, 0, 5, 20, 2, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 5, 20, 2, 0, 0, 0);
    vecs[6]  = mk(0, 1, 1, 0, 0,  0, 1, 0, 0);
    vecs[7]  = mk(0, 1, 1, 1, 4,  0, 1, 0, 0);
    vecs[8]  = mk(0, 1, 1, 2, 8,  0, 1, 1, 0);
    vecs[9]  = mk(0, 1, 0, 2, 8,  0, 0, 0, 1);
    vecs[10] = mk(0, 1, 0, 2, 8,  0, 0, 0, 0);

    // Reset state of the other instances.
    do_reset();
    @(negedge clk);
    chk("rst_b.outs", {ifb.o_valid, ifb.o_addr_ch, ifb.o_addr_act, ifb.o_addr_cprev,
                       ifb.o_first_ts, ifb.o_last_cell, ifb.o_done}, 32'd0);
    chk("rst_c.outs", {ifc.o_valid, ifc.o_addr_ch, ifc.o_addr_act, ifc.o_addr_cprev,
                       ifc.o_first_ts, ifc.o_last_cell, ifc.o_done}, 32'd0);
    step();

    // Full sweep, then again with stray start pulses.
    do_reset();
    run_table("sweep", 1'b0);
    do_reset();
    run_table("ignore", 1'b1);

    // Stall on beat ch=4.
    do_reset();
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    @(negedge clk);
    chk("stall.pre_ch", 32'(ifa.o_addr_ch), 32'd3);
    step();
    ifa.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall[%0d].valid", k), 32'(ifa.o_valid), 32'd0);
      chk($sformatf("stall[%0d].ch", k),    32'(ifa.o_addr_ch), 32'd4);
      chk($sformatf("stall[%0d].act", k),   32'(ifa.o_addr_act), 32'd16);
      step();
    end
    ifa.en = 1'b1;
    @(negedge clk);
    chk("stall.resume_valid", 32'(ifa.o_valid), 32'd1);
    chk("stall.resume_ch", 32'(ifa.o_addr_ch), 32'd4);
    step();
    @(negedge clk);
    chk("stall.next_ch", 32'(ifa.o_addr_ch), 32'd5);
    chk("stall.next_last", 32'(ifa.o_last_cell), 32'd1);
    step();
    drain_a("stall");

    // Reset mid-sweep at beat ch=1.
    do_reset();
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("midrst.ch_before", 32'(ifa.o_addr_ch), 32'd1);
    chk("midrst.valid_before", 32'(ifa.o_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.outs", {ifa.o_valid, ifa.o_addr_ch, ifa.o_addr_act, ifa.o_addr_cprev,
                        ifa.o_first_ts, ifa.o_last_cell, ifa.o_done}, 32'd0);
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      if (ifa.o_done || ifa.o_valid) dones++;
    end
    chk("midrst.quiet", 32'(dones), 32'd0);
    step();
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    @(negedge clk);
    chk("midrst.restart_ch", 32'(ifa.o_addr_ch), 32'd3);
    chk("midrst.restart_valid", 32'(ifa.o_valid), 32'd1);
    step();
    drain_a("midrst");

    // DELAY=0: six consecutive beats then done.
    exp_ch = '{3, 4, 5, 0, 1, 2};
    do_reset();
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("nodly[%0d].valid", k), 32'(ifb.o_valid), 32'd1);
      chk($sformatf("nodly[%0d].ch", k), 32'(ifb.o_addr_ch), 32'(exp_ch[k]));
      chk($sformatf("nodly[%0d].first", k), 32'(ifb.o_first_ts), 32'(k >= 3));
      step();
    end
    @(negedge clk);
    chk("nodly.done", 32'(ifb.o_done), 32'd1);
    chk("nodly.valid_after", 32'(ifb.o_valid), 32'd0);
    step();

    // Default configuration totals.
    do_reset();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    beats = 0; pauses = 0; dones = 0;
    first_ch = -1; first_act = -1; last_ch = -1; last_act = -1;
    cyc = 0;
    while (dones == 0 && cyc < 2000) begin
      @(negedge clk);
      if (ifc.o_done) begin
        dones++;
      end else if (ifc.o_valid) begin
        beats++;
        if (beats == 1) begin
          first_ch  = int'(ifc.o_addr_ch);
          first_act = int'(ifc.o_addr_act);
        end
        last_ch  = int'(ifc.o_addr_ch);
        last_act = int'(ifc.o_addr_act);
      end else begin
        pauses++;
      end
      step();
      cyc++;
    end
    chk("dflt.done_seen", 32'(dones), 32'd1);
    chk("dflt.beats", 32'(beats), 32'd371);
    chk("dflt.pause_cycles", 32'(pauses), 32'd24);
    chk("dflt.first_ch", 32'(first_ch), 32'd318);
    chk("dflt.first_act", 32'(first_act), 32'd1272);
    chk("dflt.last_ch", 32'(last_ch), 32'd52);
    chk("dflt.last_act", 32'(last_act), 32'd208);
    @(negedge clk);
    chk("dflt.done_pulse_width", 32'(ifc.o_done), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
